alu_instr_sequencer: RTL
========================

Name: alu_instr_sequencer

Overview:
- Drives the 8-bit ALU from the instruction side.
- Accepts 32-bit instruction words over a valid/ready handshake and decodes them.
- Reads operands from an internal 8x8 register file and drives the ALU operand and select inputs.
- Waits a configurable ALU latency, then writes the ALU result back to the destination register. Sits between instruction fetch and the ALU in the Lab05 CPU datapath.

Parameters:
- ALU_LATENCY, 1, cycles ALU inputs are held stable before ALU_RESULT is sampled (legal range 1..15).

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RESET  input  1  synchronous, active-low reset.
- INSTR  input  32  instruction word: [31:24] opcode, [18:16] dest, [10:8] src1, [2:0] src2, [7:0] immediate.
- INSTR_VALID  input  1  INSTR is valid.
- INSTR_READY  output  1  sequencer can accept an instruction.
- ALU_DATA1  output  8  ALU operand 1.
- ALU_DATA2  output  8  ALU operand 2.
- ALU_SELECT  output  3  ALU op: 000 MOV (pass DATA2), 001 ADD, 010 AND, 011 OR.
- ALU_RESULT  input  8  ALU output.
- BUSY  output  1  high in any state other than IDLE.
- DONE  output  1  one-cycle pulse during writeback.
- ILLEGAL  output  1  one-cycle pulse on an undefined opcode.
- DBG_ADDR  input  3  register-file debug read address.
- DBG_DATA  output  8  combinational read of reg[DBG_ADDR].

Behaviour:
- Clock and reset:
  - One clock, CLK. RESET is synchronous, active-low.
  - While RESET=0 at an edge: state=IDLE, all 8 registers=0, ALU_DATA1/ALU_DATA2/ALU_SELECT=0, DONE=ILLEGAL=0, latency counter=0.
  - After reset, INSTR_READY=1 and BUSY=0.
- Handshake:
  - INSTR_READY=1 only in IDLE.
  - An instruction is accepted on an edge where INSTR_VALID & INSTR_READY. INSTR is captured on that edge.
  - INSTR_VALID while not ready is ignored and nothing is queued.
- FSM states: IDLE -> DECODE -> EXEC -> WB -> IDLE.
  - IDLE: on accept, go to DECODE.
  - DECODE (1 cycle): read source registers and form the operands.
    - Legal opcode: ALU_DATA1, ALU_DATA2 and ALU_SELECT are registered at the exit edge; go to EXEC.
    - Illegal opcode (>5): ILLEGAL=1 this cycle, ALU ports unchanged, no write; return to IDLE.
  - EXEC (ALU_LATENCY cycles): ALU ports held constant. On the last EXEC edge, ALU_RESULT is captured into the result register; go to WB.
  - WB (1 cycle): DONE=1. reg[dest] is written at the exit edge; go to IDLE.
- Timing:
  - Acceptance at edge 0 gives DONE high in cycle ALU_LATENCY+1 (counting the cycle after edge 0 as cycle 0).
  - INSTR_READY returns one cycle after WB.
  - Throughput is one instruction per ALU_LATENCY+3 cycles.
- Opcode decode:
  - 0 loadi: DATA1=0, DATA2=imm, SEL=000.
  - 1 mov: DATA1=0, DATA2=reg[src2], SEL=000.
  - 2 add: DATA1=reg[src1], DATA2=reg[src2], SEL=001.
  - 3 sub: DATA1=reg[src1], DATA2=(~reg[src2]+1) mod 256, SEL=001. Negating 0x80 yields 0x80; negating 0x00 yields 0x00.
  - 4 and: DATA1=reg[src1], DATA2=reg[src2], SEL=010.
  - 5 or: DATA1=reg[src1], DATA2=reg[src2], SEL=011.
- Arithmetic: all 8-bit two's complement. Carry and overflow are discarded; the result wraps mod 256.
- Hazards:
  - dest may equal src1 and/or src2. Operands are read in DECODE, so old values are used.
  - Back-to-back dependent instructions see the written value, since the write completes before IDLE.
- ALU port hold: ALU ports keep their last driven values in IDLE, WB and after an illegal opcode.
- Debug port: DBG_DATA reflects a write in the cycle after the WB exit edge.
- Reset mid-operation: RESET=0 in any state aborts the instruction. No writeback, no DONE, and all registers are cleared.

Test Plan:
1. Reset: hold RESET=0 for 2 cycles, then release -> INSTR_READY=1, BUSY=0, ALU ports 0, DBG_DATA=0 for all 8 addresses.
2. ALU_LATENCY=1; loadi r1,0x05; loadi r2,0x0C; add r3,r1,r2 -> during add EXEC: DATA1=0x05, DATA2=0x0C, SEL=001. DONE occurs 2 cycles after acceptance; r3=0x11.
3. Continue from scenario 2:
   - sub r4,r1,r2 -> DATA2=0xF4; r4=0xF9 (-7).
   - and r5,r1,r2 -> r5=0x04.
   - or r6,r1,r2 -> r6=0x0D.
   - mov r7,r6 -> SEL=000, r7=0x0D.
4. Negation edge cases:
   - loadi r1,0x80; sub r2,r1,r1 -> DATA2=0x80, r2=0x00.
   - loadi r3,0x03; sub r3,r3,r3 (dest=src) -> r3=0x00.
5. Illegal opcode 0x07 with INSTR_VALID held high continuously -> ILLEGAL pulses exactly once, no DONE, registers unchanged. The next valid instruction is accepted on the first edge where INSTR_READY=1.
6. ALU_LATENCY=3:
   - add -> ALU ports stable for 3 EXEC cycles; DONE occurs 4 cycles after acceptance.
   - Assert RESET=0 during the second EXEC cycle -> no DONE, destination register reads 0, INSTR_READY=1 after reset is released.

Source files
------------

// File: rtl/alu_instr_sequencer.sv
// alu_instr_sequencer
//   Instruction-side controller for the 8-bit ALU. Accepts 32-bit instruction
//   words over a valid/ready handshake, decodes them, reads operands from an
//   internal 8x8 register file, drives the ALU operand/select inputs, waits
//   ALU_LATENCY cycles and writes the ALU result back to the destination.
//
// Ports:
//   CLK          system clock, rising edge
//   RESET        synchronous active-low reset
//   INSTR        [31:24] opcode, [18:16] dest, [10:8] src1, [2:0] src2, [7:0] imm
//   INSTR_VALID  instruction word valid
//   INSTR_READY  sequencer idle and able to accept
//   ALU_DATA1/2  ALU operands (registered, held between instructions)
//   ALU_SELECT   000 MOV(pass DATA2), 001 ADD, 010 AND, 011 OR
//   ALU_RESULT   ALU output, sampled on the last EXEC edge
//   BUSY         any state other than IDLE
//   DONE         one-cycle pulse during writeback
//   ILLEGAL      one-cycle pulse on an undefined opcode
//   DBG_ADDR     register-file debug read address
//   DBG_DATA     combinational read of reg[DBG_ADDR]
module alu_instr_sequencer #(
  parameter int ALU_LATENCY = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] INSTR,
  input  logic        INSTR_VALID,
  output logic        INSTR_READY,
  output logic [7:0]  ALU_DATA1,
  output logic [7:0]  ALU_DATA2,
  output logic [2:0]  ALU_SELECT,
  input  logic [7:0]  ALU_RESULT,
  output logic        BUSY,
  output logic        DONE,
  output logic        ILLEGAL,
  input  logic [2:0]  DBG_ADDR,
  output logic [7:0]  DBG_DATA
);

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

  localparam logic [3:0] LAST_CNT = 4'(ALU_LATENCY - 1);

  state_t     state, state_nxt;
  logic [7:0] opcode;
  logic [2:0] dest, src1, src2;
  logic [7:0] imm;
  logic [7:0] regs [8];
  logic [3:0] cnt;
  logic [7:0] result;
  logic       accept;
  logic       legal;
  logic [7:0] data1_nxt, data2_nxt;
  logic [2:0] sel_nxt;

  // Reserved instruction bits are intentionally ignored.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{INSTR[23:19], INSTR[15:11]};

  // Two's-complement negation; -0x80 wraps back to 0x80.
  function automatic logic [7:0] negate(input logic signed [7:0] v);
    logic signed [7:0] n;
    n = -v;
    return n;
  endfunction

  assign accept   = INSTR_VALID & INSTR_READY;
  assign legal    = (opcode <= 8'd5);
  assign DBG_DATA = regs[DBG_ADDR];

  // Operand formation from the captured instruction and current register file.
  always_comb begin
    data1_nxt = ALU_DATA1;
    data2_nxt = ALU_DATA2;
    sel_nxt   = ALU_SELECT;
    case (opcode)
      8'd0: begin data1_nxt = 8'h00;      data2_nxt = imm;                sel_nxt = 3'b000; end
      8'd1: begin data1_nxt = 8'h00;      data2_nxt = regs[src2];         sel_nxt = 3'b000; end
      8'd2: begin data1_nxt = regs[src1]; data2_nxt = regs[src2];         sel_nxt = 3'b001; end
      8'd3: begin data1_nxt = regs[src1]; data2_nxt = negate(regs[src2]); sel_nxt = 3'b001; end
      8'd4: begin data1_nxt = regs[src1]; data2_nxt = regs[src2];         sel_nxt = 3'b010; end
      8'd5: begin data1_nxt = regs[src1]; data2_nxt = regs[src2];         sel_nxt = 3'b011; end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt   = state;
    INSTR_READY = 1'b0;
    BUSY        = 1'b1;
    DONE        = 1'b0;
    ILLEGAL     = 1'b0;
    case (state)
      IDLE: begin
        INSTR_READY = 1'b1;
        BUSY        = 1'b0;
        if (INSTR_VALID) state_nxt = DECODE;
      end
      DECODE: begin
        if (legal) begin
          state_nxt = EXEC;
        end else begin
          ILLEGAL   = 1'b1;
          state_nxt = IDLE;
        end
      end
      EXEC: begin
        if (cnt == LAST_CNT) state_nxt = WB;
      end
      WB: begin
        DONE      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Instruction capture: pure data, only loaded on an accepted handshake.
  always_ff @(posedge CLK) begin
    if (accept) begin
      opcode <= INSTR[31:24];
      dest   <= INSTR[18:16];
      src1   <= INSTR[10:8];
      src2   <= INSTR[2:0];
      imm    <= INSTR[7:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state      <= IDLE;
      ALU_DATA1  <= 8'h00;
      ALU_DATA2  <= 8'h00;
      ALU_SELECT <= 3'b000;
      cnt        <= 4'd0;
      result     <= 8'h00;
      for (int i = 0; i < 8; i++) regs[i] <= 8'h00;
    end else begin
      state <= state_nxt;
      case (state)
        DECODE: begin
          if (legal) begin
            ALU_DATA1  <= data1_nxt;
            ALU_DATA2  <= data2_nxt;
            ALU_SELECT <= sel_nxt;
            cnt        <= 4'd0;
          end
        end
        EXEC: begin
          if (cnt == LAST_CNT) result <= ALU_RESULT;
          else                 cnt    <= cnt + 4'd1;
        end
        WB: regs[dest] <= result;
        default: ;
      endcase
    end
  end

endmodule
